buffer_reader: RTL and testbench

BUFFER_READER -- requirements
Module: buffer_reader

---
 rtl/tpu_buffer_pkg.sv | 17 +
 rtl/buffer_reader_fifo.sv | 57 +++++
 rtl/buffer_reader.sv | 122 ++++++++++++
 tb/tb_buffer_reader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_buffer_pkg
// Description : Shared constants for the TPU global-buffer readers.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_buffer_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 16;
    localparam int c_DEFAULT_ADDR_WIDTH = 10;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

endpackage : tpu_buffer_pkg
`default_nettype wire

// File: rtl/buffer_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : buffer_reader_fifo
// Description : Two-entry output FIFO; head is visible combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_reader_fifo #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_pop  = pop && (r_count != 2'd0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule : buffer_reader_fifo
`default_nettype wire

// File: rtl/buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : buffer_reader
// Description : Burst reader streaming global-buffer words to a ready/valid sink.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_reader
    import tpu_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH:0]   r_popped;
    logic                  r_inflight;
    logic                  r_done;

    logic [1:0]            w_count;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occupancy;
    logic [2:0]            w_limit;
    logic [ADDR_WIDTH:0]   w_issued_next;
    logic [ADDR_WIDTH:0]   w_popped_next;

    assign w_pop         = out_valid && out_ready;
    assign w_occupancy   = {1'b0, w_count} + {2'b00, r_inflight};
    // A slot freed by this cycle's pop can be refilled by a read issued now.
    assign w_limit       = w_pop ? 3'd3 : 3'd2;
    assign w_issue       = (r_state == c_RUN) && (w_occupancy < w_limit);
    assign w_issued_next = r_issued + (ADDR_WIDTH+1)'(1);
    assign w_popped_next = r_popped + (ADDR_WIDTH+1)'(1);

    assign read_enable = w_issue;
    assign addr        = r_base + r_issued[ADDR_WIDTH-1:0];
    assign busy        = (r_state != c_IDLE);
    assign done        = r_done;
    assign out_valid   = (w_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_base   <= base_addr;
                            r_len    <= length;
                            r_issued <= '0;
                            r_popped <= '0;
                            r_state  <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    if (w_issue) begin
                        r_issued <= w_issued_next;
                        if (w_issued_next == r_len) begin
                            r_state <= c_DRAIN;
                        end
                    end
                    if (w_pop) begin
                        r_popped <= w_popped_next;
                    end
                end
                c_DRAIN: begin
                    if (w_pop) begin
                        r_popped <= w_popped_next;
                        if (w_popped_next == r_len) begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    buffer_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (r_data),
        .pop       (w_pop),
        .count     (w_count),
        .head      (out_data)
    );

endmodule : buffer_reader
`default_nettype wire

// File: tb/tb_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_reader
// Description : Directed self-checking bench for buffer_reader (mem[i] = i).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        read_enable;
    logic [9:0]  addr;
    logic [15:0] r_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    buffer_reader #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .read_enable (read_enable),
        .addr        (addr),
        .r_data      (r_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global buffer model: mem[i] = i, one-cycle read latency.
    initial r_data = 16'h0000;
    always @(posedge clk) begin
        if (read_enable) r_data <= {6'b000000, addr};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_enable"}, 32'(read_enable), 32'd0);
        check({tag, "_addr"},        32'(addr),        32'd0);
        check({tag, "_out_valid"},   32'(out_valid),   32'd0);
        check({tag, "_out_data"},    32'(out_data),    32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
    endtask

    // Runs one burst from the current negedge; stall applies ready 1,0,0,1...
    // intr > 0 re-asserts start with a different base/length in that cycle.
    task automatic run_burst(input string name, input logic [9:0] b, input logic [10:0] n,
                             input bit stall, input int intr);
        int  acc = 0;
        int  iss = 0;
        int  cyc = 1;
        bit  got_done = 1'b0;
        logic [9:0] exp_a;
        start = 1'b1; base_addr = b; length = n; out_ready = 1'b1;
        @(negedge clk);
        while (!got_done && cyc < 200) begin
            out_ready = stall ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
            if (cyc == intr) begin
                start = 1'b1; base_addr = 10'h300; length = 11'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (out_valid) begin
                exp_a = b + 10'(acc);
                check({name, "_out_data"}, 32'(out_data), 32'(exp_a));
                if (out_ready) acc++;
            end
            if (read_enable) begin
                exp_a = b + 10'(iss);
                check({name, "_addr"}, 32'(addr), 32'(exp_a));
                iss++;
            end
            check({name, "_outstanding_le2"}, 32'((iss - acc) <= 2), 32'd1);
            check({name, "_reads_le_len"},    32'(iss <= int'(n)), 32'd1);
            if (done) begin
                got_done = 1'b1;
                check({name, "_done_words"},  acc, 32'(n));
                check({name, "_done_idle"},   32'(busy), 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        check({name, "_done_seen"}, 32'(got_done), 32'd1);
        check({name, "_reads"},     iss, 32'(n));
    endtask

    typedef struct {
        logic        start;
        logic [9:0]  base;
        logic [10:0] len;
        logic        rdy;
        logic        re;
        logic [9:0]  addr;
        logic        ov;
        logic [15:0] data;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // Cycle-by-cycle: base 0x010 len 4, then 0x3FE len 4 started in the
        // done cycle (address wrap), then length 0 started in the next done cycle.
        tbl[0]  = '{1'b1, 10'h010, 11'd4, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h010, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h011, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h012, 1'b1, 16'h0010, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h013, 1'b1, 16'h0011, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b0, 10'h000, 1'b1, 16'h0012, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b0, 10'h000, 1'b1, 16'h0013, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 10'h3FE, 11'd4, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h3FE, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h3FF, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h000, 1'b1, 16'h03FE, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b1, 10'h001, 1'b1, 16'h03FF, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b0, 10'h000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b0, 10'h000, 1'b1, 16'h0001, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 10'h123, 11'd0, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 10'h000, 11'd0, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            start = tbl[i].start; base_addr = tbl[i].base;
            length = tbl[i].len; out_ready = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_read_enable", i), 32'(read_enable), 32'(tbl[i].re));
            if (tbl[i].re)
                check($sformatf("tbl%0d_addr", i), 32'(addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov)
                check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].data));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
            @(negedge clk);
        end
        start = 1'b0;

        run_burst("stall", 10'h050, 11'd8, 1'b1, -1);
        run_burst("busy_start", 10'h020, 11'd6, 1'b0, 2);

        // Reset in cycle 4 of a 16-word burst.
        start = 1'b1; base_addr = 10'h100; length = 11'd16; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort_nodone%0d", i), 32'(done), 32'd0);
            check($sformatf("abort_idle%0d", i), 32'(busy | read_enable | out_valid), 32'd0);
        end
        @(negedge clk);
        run_burst("post_rst", 10'h200, 11'd2, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_buffer_reader
`default_nettype wire
